// File: rtl/imm_extend_stage_pkg.sv
// Shared decode definitions: immediate extension modes, default widths, skid buffer states.
package imm_extend_stage_pkg;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_TAG_W = 5;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational mode-selected immediate extender (zero/sign/upper/branch); shared with jump-target logic.
// No latency, no handshake.
module imm_extend_comb
  import imm_extend_stage_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    ext = '0;
    case (mode)
      EXT_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_SIGN:   ext = sext;
      EXT_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      // OUT_W >= IN_W+2 guarantees the two dropped bits are sign copies
      EXT_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage, 1-cycle latency, valid/ready with 2-entry skid;
// in_ready depends only on registered state, so full throughput holds under back-pressure.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_extend_stage: OUT_W must be at least IN_W+2");
  end

  skid_state_t      state, next_state;
  logic [OUT_W-1:0] ext_imm;
  logic [OUT_W-1:0] main_imm, skid_imm;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             in_xfer, out_xfer;
  logic             load_main, load_skid, skid_to_main;

  imm_extend_comb #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext_imm)
  );

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_imm   = main_imm;
  assign out_tag   = main_tag;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          next_state = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          next_state = ST_TWO;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          next_state = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          next_state   = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
    // Flush drops both entries and the input offered this cycle
    if (flush) begin
      next_state   = ST_EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_imm <= '0;
      main_tag <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else begin
      if (load_main) begin
        main_imm <= ext_imm;
        main_tag <= in_tag;
      end else if (skid_to_main) begin
        main_imm <= skid_imm;
        main_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= ext_imm;
        skid_tag <= in_tag;
      end
    end
  end

endmodule
